// File: rtl/mhp_calc_engine.sv
// mhp_calc_engine: arithmetic task engine (ADD/SUB/MUL/FIB, optional DIV) with a result FIFO
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_task_valid/o_task_ready, i_opcode, i_op_a, i_op_b   task request handshake
//   o_res_valid/i_res_ready, o_res_data, o_res_status     FWFT result FIFO head
//   o_busy               engine not idle
//   o_task_cnt           accepted-task counter (wraps)
//   Define MHP_CALC_DIV_EN to add opcode 0x70 (restoring divider, one bit per cycle).
module mhp_calc_engine #(
  parameter int DATA_W = 16,
  parameter int QDEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_task_valid,
  output logic              o_task_ready,
  input  logic [7:0]        i_opcode,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic [1:0]        o_res_status,
  output logic              o_busy,
  output logic [7:0]        o_task_cnt
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] OP_ADD = 8'h10, OP_SUB = 8'h20, OP_MUL = 8'h30, OP_FIB = 8'h60;
`ifdef MHP_CALC_DIV_EN
  localparam logic [7:0] OP_DIV = 8'h70;
  localparam int DCW = $clog2(DATA_W);
`endif
  typedef enum logic [2:0] {IDLE, EXEC, FIB, DIV, PUSH} state_t;
  state_t state, state_n;
  logic [7:0] opc, cnt;
  logic [DATA_W-1:0] op_a, op_b, res, fb;
  logic a_wrap, b_wrap;
  logic [1:0] stat;
  logic [DATA_W:0] sum, diff, fsum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W+1:0] mem [QDEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic accept, push, pop;
  assign o_task_ready = (state == IDLE) && (count < CW'(QDEPTH));
  assign accept = i_task_valid && o_task_ready;
  assign push = state == PUSH;
  assign pop = o_res_valid && i_res_ready;
  assign o_busy = state != IDLE;
  assign o_res_valid = count != '0;
  // Head is forced to zero while empty so reset/idle outputs read as 0.
  assign {o_res_status, o_res_data} = o_res_valid ? mem[rp] : '0;
  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
  // FIB keeps a in res so the final value is already in the result register.
  assign fsum = {1'b0, res} + {1'b0, fb};
`ifdef MHP_CALC_DIV_EN
  logic [DATA_W-1:0] rem;
  logic [DCW-1:0] dcnt;
  logic [DATA_W:0] rsh, rdiff;
  // Quotient bits shift into res as the dividend bits shift out of it.
  assign rsh = {rem, res[DATA_W-1]};
  assign rdiff = rsh - {1'b0, op_b};
`endif
  always_ff @(posedge i_clk)
    state <= !i_rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? EXEC : IDLE;
      EXEC: begin
        state_n = PUSH;
        if (opc == OP_FIB) state_n = FIB;
`ifdef MHP_CALC_DIV_EN
        if (opc == OP_DIV) state_n = DIV;
`endif
      end
      FIB: state_n = cnt == 8'd0 ? PUSH : FIB;
`ifdef MHP_CALC_DIV_EN
      DIV: state_n = dcnt == '0 ? PUSH : DIV;
`endif
      PUSH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      opc <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      fb <= '0;
      cnt <= '0;
      a_wrap <= 1'b0;
      b_wrap <= 1'b0;
      stat <= '0;
      o_task_cnt <= '0;
`ifdef MHP_CALC_DIV_EN
      rem <= '0;
      dcnt <= '0;
`endif
    end else begin
      if (accept) begin
        opc <= i_opcode;
        op_a <= i_op_a;
        op_b <= i_op_b;
        o_task_cnt <= o_task_cnt + 8'd1;
      end
      if (state == EXEC) begin
        case (opc)
          OP_ADD: begin res <= sum[DATA_W-1:0]; stat <= {1'b0, sum[DATA_W]}; end
          OP_SUB: begin res <= diff[DATA_W-1:0]; stat <= {1'b0, diff[DATA_W]}; end
          OP_MUL: begin res <= prod[DATA_W-1:0]; stat <= {1'b0, |prod[2*DATA_W-1:DATA_W]}; end
          OP_FIB: begin
            res <= '0;
            fb <= DATA_W'(1);
            cnt <= op_a[7:0];
            a_wrap <= 1'b0;
            b_wrap <= 1'b0;
            stat <= '0;
          end
`ifdef MHP_CALC_DIV_EN
          OP_DIV: begin
            res <= op_a;
            rem <= '0;
            dcnt <= DCW'(DATA_W - 1);
            stat <= op_b == '0 ? 2'b10 : 2'b00;
          end
`endif
          default: begin res <= '0; stat <= 2'b10; end
        endcase
      end
      if (state == FIB) begin
        if (cnt == 8'd0) stat <= {1'b0, a_wrap};
        else begin
          res <= fb;
          fb <= fsum[DATA_W-1:0];
          cnt <= cnt - 8'd1;
          b_wrap <= b_wrap | fsum[DATA_W];
          a_wrap <= b_wrap;
        end
      end
`ifdef MHP_CALC_DIV_EN
      // Divide by zero never goes negative, so the quotient naturally becomes all ones.
      if (state == DIV) begin
        res <= {res[DATA_W-2:0], ~rdiff[DATA_W]};
        rem <= rdiff[DATA_W] ? rsh[DATA_W-1:0] : rdiff[DATA_W-1:0];
        dcnt <= dcnt - DCW'(1);
      end
`endif
    end
  end
  always_ff @(posedge i_clk)
    if (push) mem[wp] <= {stat, res};
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_mhp_calc_engine.sv
// tb_mhp_calc_engine: scoreboard bench for mhp_calc_engine against a behavioural model
module tb_mhp_calc_engine;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, task_valid = 0, res_ready = 0;
  logic task_ready, res_valid, busy;
  logic [7:0] opcode = 0, task_cnt;
  logic [W-1:0] op_a = 0, op_b = 0, res_data;
  logic [1:0] res_status;
  int total = 0, bad = 0;
  logic [17:0] exp_q[$];
  bit rand_rdy = 0;

  always #5 clk = ~clk;

  mhp_calc_engine #(.DATA_W(W), .QDEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_task_valid(task_valid), .o_task_ready(task_ready),
    .i_opcode(opcode), .i_op_a(op_a), .i_op_b(op_b), .o_res_valid(res_valid),
    .i_res_ready(res_ready), .o_res_data(res_data), .o_res_status(res_status),
    .o_busy(busy), .o_task_cnt(task_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on wide integers, status from true magnitude.
  function automatic logic [17:0] model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, t, lim;
    logic [W-1:0] d;
    logic [1:0] s;
    lim = 64'd1 << W;
    case (op)
      8'h10: begin t = longint'(a) + longint'(b); d = W'(t); s = t >= lim ? 2'b01 : 2'b00; end
      8'h20: begin t = longint'(a) - longint'(b); d = W'(t); s = a < b ? 2'b01 : 2'b00; end
      8'h30: begin t = longint'(a) * longint'(b); d = W'(t); s = t >= lim ? 2'b01 : 2'b00; end
      8'h60: begin
        x = 0; y = 1;
        d = '0;
        for (int i = 0; i < int'(a[7:0]); i++) begin
          t = x + y;
          if (t > (64'd1 << 40)) t = 64'd1 << 40;
          x = y; y = t;
        end
        // true value capped; mod result computed separately by iterating mod 2^W
        begin
          logic [W-1:0] xm, ym, tm;
          xm = '0; ym = W'(1);
          for (int i = 0; i < int'(a[7:0]); i++) begin tm = xm + ym; xm = ym; ym = tm; end
          d = xm;
        end
        s = x >= lim ? 2'b01 : 2'b00;
      end
`ifdef MHP_CALC_DIV_EN
      8'h70: begin
        if (b == 0) begin d = '1; s = 2'b10; end
        else begin d = a / b; s = 2'b00; end
      end
`endif
      default: begin d = '0; s = 2'b10; end
    endcase
    return {s, d};
  endfunction

  // Monitor: compares the FIFO head whenever a pop is about to happen.
  initial forever begin
    @(negedge clk); #2;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious result: got %0h expected none", {res_status, res_data});
      end else check("result", {14'd0, res_status, res_data}, {14'd0, exp_q.pop_front()});
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    opcode = op; op_a = a; op_b = b; task_valid = 1;
    for (int i = 0; i < 3000 && !task_ready; i++) @(negedge clk);
    if (!task_ready) begin
      total++; bad++;
      $display("FAIL send timeout: got ready=0 expected ready=1");
      task_valid = 0;
    end else begin
      @(posedge clk);
      exp_q.push_back(model(op, a, b));
      #1 task_valid = 0;
    end
  endtask

  task automatic latency(input string name, input int exp_k);
    int k;
    for (k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      if (res_valid) break;
    end
    check(name, k, exp_k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && (busy || res_valid); i++) @(negedge clk);
    check("idle", {30'd0, busy, res_valid}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); @(negedge clk);
    exp_q.delete();
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    total++; bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] ops[6];
    int seen;
    ops[0] = 8'h10; ops[1] = 8'h20; ops[2] = 8'h30; ops[3] = 8'h60; ops[4] = 8'h70; ops[5] = 8'h55;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset valid", res_valid, 0);
    check("reset data", res_data, 0);
    check("reset status", res_status, 0);
    check("reset busy", busy, 0);
    check("reset cnt", task_cnt, 0);
    check("reset ready", task_ready, 1);

    res_ready = 1;
    send(8'h10, 16'h1234, 16'h0001);
    latency("add latency", 2);
    check("add data", res_data, 16'h1235);
    check("add status", res_status, 0);
    send(8'h10, 16'hFFFF, 16'h0001);
    send(8'h20, 16'h0001, 16'h0002);
    send(8'h30, 16'h00FF, 16'h0101);
    send(8'h30, 16'h0100, 16'h0100);
    send(8'h55, 16'h1111, 16'h2222);
    send(8'h60, 16'd0, 16'h1234);
    latency("fib0 latency", 3);
    send(8'h60, 16'd24, 16'h0);
    latency("fib24 latency", 27);
    check("fib24 data", res_data, 16'hB520);
    send(8'h60, 16'd25, 16'h0);
    latency("fib25 latency", 28);
    check("fib25 data", {res_status, res_data}, {2'b01, 16'h2511});
    send(8'h70, 16'd100, 16'd7);
`ifdef MHP_CALC_DIV_EN
    latency("div latency", 18);
    check("div data", {res_status, res_data}, {2'b00, 16'd14});
`else
    latency("div latency", 2);
    check("div data", {res_status, res_data}, {2'b10, 16'd0});
`endif
    send(8'h70, 16'd5, 16'd0);
    wait_idle();

    // back-pressure: four fill the FIFO, the fifth is held until one pop
    do_reset();
    res_ready = 0;
    for (int i = 0; i < 4; i++) send(8'h10, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("full ready", task_ready, 0);
    fork
      send(8'h10, 16'h0F0F, 16'h0101);
      begin
        repeat (3) @(negedge clk);
        check("held ready", task_ready, 0);
        check("held cnt", task_cnt, 4);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
      end
    join
    check("cnt five", task_cnt, 5);
    res_ready = 1;
    wait_idle();
    check("bp drained", exp_q.size(), 0);

    // pop coincides with push while 3 entries are queued
    do_reset();
    res_ready = 0;
    for (int i = 0; i < 3; i++) send(8'h20, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    send(8'h30, 16'($urandom), 16'($urandom));
    @(negedge clk);
    @(negedge clk); res_ready = 1;
    @(negedge clk); res_ready = 0;
    check("pushpop ready", task_ready, 1);
    check("pushpop busy", busy, 0);
    res_ready = 1;
    wait_idle();
    check("pushpop drained", exp_q.size(), 0);

    // reset during a long FIB discards it
    send(8'h60, 16'd20, 16'h0);
    repeat (5) @(negedge clk);
    rst_n = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst busy", busy, 0);
    check("rst valid", res_valid, 0);
    seen = 0;
    repeat (30) begin @(negedge clk); if (res_valid) seen++; end
    check("rst no result", seen, 0);

    // randomized traffic with random consumer back-pressure
    rand_rdy = 1;
    repeat (60) begin
      logic [7:0] op;
      logic [W-1:0] a, b;
      op = ops[$urandom_range(0, 5)];
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3));
      if (op == 8'h60) a = 16'($urandom_range(0, 40));
      if (op == 8'h55) op = 8'($urandom);
      send(op, a, b);
    end
    rand_rdy = 0;
    @(negedge clk);
    res_ready = 1;
    wait_idle();
    check("final drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
